// File: rtl/wordline_burst_decoder_pkg.sv
// Shared types and default sizing for the wordline burst decoder.
// Defaults match the memory subsystem's 2-bit row address and 3-bit burst length.
package wordline_burst_decoder_pkg;

    localparam int DEFAULT_ADDR_W   = 2;
    localparam int DEFAULT_LEN_W    = 3;
    localparam int DEFAULT_WRAP_LEN = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } burst_state_e;

endpackage

// File: rtl/wordline_burst_decoder_onehot.sv
// Combinational address to one-hot wordline select.
// The parent registers this output, so no timing is added here.
module wordline_burst_decoder_onehot #(
    parameter int ADDR_W = 2,
    localparam int NWL   = 1 << ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [NWL-1:0]    sel
);

    always_comb begin
        sel       = '0;
        sel[addr] = 1'b1;
    end

endmodule

// File: rtl/wordline_burst_decoder.sv
// Registered address-to-wordline decoder with a linear or wrapping burst engine
// and output back-pressure; one one-hot wordline select per beat.
module wordline_burst_decoder
    import wordline_burst_decoder_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int LEN_W    = DEFAULT_LEN_W,
    parameter int WRAP_LEN = DEFAULT_WRAP_LEN,
    localparam int NWL     = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              req_wrap,
    output logic [NWL-1:0]    wl_sel,
    output logic              wl_valid,
    output logic              wl_last,
    input  logic              wl_ready,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] WRAP_MASK = ADDR_W'(WRAP_LEN - 1);

    burst_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              wrap_q, wrap_d;
    logic [NWL-1:0]    wl_sel_q, wl_sel_d, dec_sel;
    logic              wl_valid_q, wl_valid_d;
    logic              wl_last_q, wl_last_d;
    logic              busy_q, busy_d;
    logic              rdy_en_q;
    logic              accept, consume;

    // A new burst may be taken while idle or in the same cycle the final beat drains.
    assign req_ready = rdy_en_q & ((state_q == ST_IDLE) | (wl_valid_q & wl_last_q & wl_ready));
    assign accept    = req_valid & req_ready;
    assign consume   = wl_valid_q & wl_ready;

    always_comb begin
        addr_inc = addr_q + ADDR_W'(1);
        if (wrap_q) begin
            addr_inc = (addr_q & ~WRAP_MASK) | ((addr_q + ADDR_W'(1)) & WRAP_MASK);
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        wrap_d     = wrap_q;
        wl_valid_d = wl_valid_q;
        wl_last_d  = wl_last_q;
        if (accept) begin
            state_d    = ST_BURST;
            addr_d     = req_addr;
            cnt_d      = req_len;
            wrap_d     = req_wrap;
            wl_valid_d = 1'b1;
            wl_last_d  = (req_len == '0);
        end else if (consume) begin
            if (cnt_q == '0) begin
                state_d    = ST_IDLE;
                wl_valid_d = 1'b0;
                wl_last_d  = 1'b0;
            end else begin
                cnt_d     = cnt_q - LEN_W'(1);
                addr_d    = addr_inc;
                wl_last_d = (cnt_q == LEN_W'(1));
            end
        end
        busy_d   = (state_d == ST_BURST);
        wl_sel_d = wl_valid_d ? dec_sel : '0;
    end

    wordline_burst_decoder_onehot #(
        .ADDR_W(ADDR_W)
    ) u_onehot (
        .addr(addr_d),
        .sel (dec_sel)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            wrap_q     <= 1'b0;
            wl_sel_q   <= '0;
            wl_valid_q <= 1'b0;
            wl_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            wrap_q     <= wrap_d;
            wl_sel_q   <= wl_sel_d;
            wl_valid_q <= wl_valid_d;
            wl_last_q  <= wl_last_d;
            busy_q     <= busy_d;
            rdy_en_q   <= 1'b1;
        end
    end

    assign wl_sel   = wl_sel_q;
    assign wl_valid = wl_valid_q;
    assign wl_last  = wl_last_q;
    assign busy     = busy_q;

endmodule
